// File: rtl/cc1200_apb_regs_fifo_if.sv
//==============================================================================
// Module  : cc1200_apb_regs_fifo_if
// APB3 bus bundle between the PS APB bridge (master) and the CC1200 register block.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface cc1200_apb_regs_fifo_if;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/cc1200_apb_regs_fifo.sv
//==============================================================================
// Module  : cc1200_apb_regs_fifo
// APB3 register file with TX/RX FIFOs, START pulse and W1C interrupts for the
// CC1200 SPI/packet core. Define CC1200_APB_SLVERR_EN to enable pslverr.
// Revision: 1.0
//==============================================================================
`default_nettype none

module cc1200_apb_regs_fifo #(
  parameter int GPIO_W = 4,
  parameter int TXF_AW = 4,
  parameter int RXF_AW = 4
) (
  input  logic                clk,
  input  logic                rst,
  cc1200_apb_regs_fifo_if.slave apb,
  output logic                start,
  input  logic                busy,
  output logic                trans,
  output logic                receive,
  output logic [3:0]          wr,
  output logic [15:0]         clk_div,
  output logic [7:0]          tx_pkt_size,
  output logic [7:0]          rx_pkt_size,
  output logic [15:0]         tx_wait,
  output logic [GPIO_W-1:0]   gpio_oe,
  output logic [GPIO_W-1:0]   gpio_out,
  input  logic [GPIO_W-1:0]   gpio_in,
  input  logic                tx_rd_en,
  output logic [31:0]         tx_rd_data,
  output logic                tx_empty,
  input  logic                rx_wr_en,
  input  logic [31:0]         rx_wr_data,
  output logic                rx_full,
  output logic                irq
);
  localparam int       c_TX_DEPTH = 2**TXF_AW;
  localparam int       c_RX_DEPTH = 2**RXF_AW;
  localparam bit [5:0] c_A_CTRL = 6'd0,  c_A_STATUS = 6'd1,  c_A_TXDATA = 6'd2,  c_A_RXDATA = 6'd3;
  localparam bit [5:0] c_A_WR   = 6'd4,  c_A_CLKDIV = 6'd5,  c_A_GPOE   = 6'd6,  c_A_GPOUT  = 6'd7;
  localparam bit [5:0] c_A_GPIN = 6'd8,  c_A_TXPKT  = 6'd9,  c_A_RXPKT  = 6'd10, c_A_TXWAIT = 6'd11;
  localparam bit [5:0] c_A_ISTAT = 6'd12, c_A_IMASK = 6'd13;

  logic              r_pready, r_start, r_trans, r_receive, r_busy, r_tx_empty_q, r_rx_empty_q;
  logic [3:0]        r_wr;
  logic [15:0]       r_clk_div, r_tx_wait;
  logic [7:0]        r_tx_pkt, r_rx_pkt;
  logic [GPIO_W-1:0] r_gpio_oe, r_gpio_out;
  logic [4:0]        r_irq_stat, r_irq_mask;
  logic [31:0]       r_tx_mem [c_TX_DEPTH];
  logic [31:0]       r_rx_mem [c_RX_DEPTH];
  logic [TXF_AW:0]   r_tx_wp, r_tx_rp;
  logic [RXF_AW:0]   r_rx_wp, r_rx_rp;

  logic [5:0]  w_idx;
  logic        w_commit, w_err, w_wr, w_rd, w_unused;
  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic        w_tx_push_req, w_tx_push, w_tx_pop, w_tx_ovf;
  logic        w_rx_pop_req, w_rx_push, w_rx_pop, w_rx_ovf;
  logic [TXF_AW:0] w_tx_level;
  logic [RXF_AW:0] w_rx_level;
  logic [4:0]  w_events, w_w1c;
  logic [31:0] w_rdata;

  assign w_idx    = apb.paddr[7:2];
  assign w_commit = apb.psel & apb.penable & r_pready;
  assign w_unused = ^{apb.paddr[1:0], apb.pwdata[31:16]};

`ifdef CC1200_APB_SLVERR_EN
  assign w_err = r_pready & ((w_idx > c_A_IMASK)
               | (apb.pwrite & (w_idx == c_A_STATUS | w_idx == c_A_RXDATA | w_idx == c_A_GPIN))
               | (apb.pwrite & (w_idx == c_A_TXDATA) & w_tx_full)
               | (~apb.pwrite & (w_idx == c_A_RXDATA) & w_rx_empty));
  assign apb.pslverr = w_err;
`else
  assign w_err       = 1'b0;
  assign apb.pslverr = 1'b0;
`endif

  assign w_wr = w_commit & apb.pwrite & ~w_err;
  assign w_rd = w_commit & ~apb.pwrite & ~w_err;

  // Full/empty come from AW+1-bit pointers; simultaneous push+pop always both proceed.
  assign w_tx_level    = r_tx_wp - r_tx_rp;
  assign w_tx_empty    = (r_tx_wp == r_tx_rp);
  assign w_tx_full     = (r_tx_wp[TXF_AW] != r_tx_rp[TXF_AW]) && (r_tx_wp[TXF_AW-1:0] == r_tx_rp[TXF_AW-1:0]);
  assign w_tx_push_req = w_wr & (w_idx == c_A_TXDATA);
  assign w_tx_push     = w_tx_push_req & (~w_tx_full | tx_rd_en);
  assign w_tx_pop      = tx_rd_en & (~w_tx_empty | w_tx_push_req);
  assign w_tx_ovf      = w_tx_push_req & w_tx_full & ~tx_rd_en;

  assign w_rx_level    = r_rx_wp - r_rx_rp;
  assign w_rx_empty    = (r_rx_wp == r_rx_rp);
  assign w_rx_full     = (r_rx_wp[RXF_AW] != r_rx_rp[RXF_AW]) && (r_rx_wp[RXF_AW-1:0] == r_rx_rp[RXF_AW-1:0]);
  assign w_rx_pop_req  = w_rd & (w_idx == c_A_RXDATA);
  assign w_rx_push     = rx_wr_en & (~w_rx_full | w_rx_pop_req);
  assign w_rx_pop      = w_rx_pop_req & (~w_rx_empty | rx_wr_en);
  assign w_rx_ovf      = rx_wr_en & w_rx_full & ~w_rx_pop_req;

  assign w_events = {w_rx_ovf, w_tx_ovf, r_rx_empty_q & ~w_rx_empty, ~r_tx_empty_q & w_tx_empty, r_busy & ~busy};
  assign w_w1c    = (w_wr && w_idx == c_A_ISTAT) ? apb.pwdata[4:0] : 5'd0;

  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      c_A_CTRL:   w_rdata = {29'd0, r_receive, r_trans, 1'b0};
      c_A_STATUS: w_rdata = {11'd0, 5'(w_rx_level), 3'd0, 5'(w_tx_level), 3'd0,
                             w_rx_full, w_rx_empty, w_tx_full, w_tx_empty, busy};
      c_A_RXDATA: w_rdata = w_rx_empty ? 32'd0 : r_rx_mem[r_rx_rp[RXF_AW-1:0]];
      c_A_WR:     w_rdata = {28'd0, r_wr};
      c_A_CLKDIV: w_rdata = {16'd0, r_clk_div};
      c_A_GPOE:   w_rdata = 32'(r_gpio_oe);
      c_A_GPOUT:  w_rdata = 32'(r_gpio_out);
      c_A_GPIN:   w_rdata = 32'(gpio_in);
      c_A_TXPKT:  w_rdata = {24'd0, r_tx_pkt};
      c_A_RXPKT:  w_rdata = {24'd0, r_rx_pkt};
      c_A_TXWAIT: w_rdata = {16'd0, r_tx_wait};
      c_A_ISTAT:  w_rdata = {27'd0, r_irq_stat};
      c_A_IMASK:  w_rdata = {27'd0, r_irq_mask};
      default:    w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pready <= 1'b0;  r_start <= 1'b0;  r_trans <= 1'b0;  r_receive <= 1'b0;
      r_wr <= '0;  r_clk_div <= '0;  r_tx_wait <= '0;  r_tx_pkt <= '0;  r_rx_pkt <= '0;
      r_gpio_oe <= '0;  r_gpio_out <= '0;  r_irq_stat <= '0;  r_irq_mask <= '0;
      r_tx_wp <= '0;  r_tx_rp <= '0;  r_rx_wp <= '0;  r_rx_rp <= '0;
      r_busy <= 1'b0;  r_tx_empty_q <= 1'b1;  r_rx_empty_q <= 1'b1;
    end else begin
      r_pready     <= apb.psel & apb.penable & ~r_pready;
      r_start      <= w_wr & (w_idx == c_A_CTRL) & apb.pwdata[0];
      r_busy       <= busy;
      r_tx_empty_q <= w_tx_empty;
      r_rx_empty_q <= w_rx_empty;
      r_irq_stat   <= (r_irq_stat & ~w_w1c) | w_events;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_wr) begin
        case (w_idx)
          c_A_CTRL:   begin r_trans <= apb.pwdata[1]; r_receive <= apb.pwdata[2]; end
          c_A_WR:     r_wr       <= apb.pwdata[3:0];
          c_A_CLKDIV: r_clk_div  <= apb.pwdata[15:0];
          c_A_GPOE:   r_gpio_oe  <= apb.pwdata[GPIO_W-1:0];
          c_A_GPOUT:  r_gpio_out <= apb.pwdata[GPIO_W-1:0];
          c_A_TXPKT:  r_tx_pkt   <= apb.pwdata[7:0];
          c_A_RXPKT:  r_rx_pkt   <= apb.pwdata[7:0];
          c_A_TXWAIT: r_tx_wait  <= apb.pwdata[15:0];
          c_A_IMASK:  r_irq_mask <= apb.pwdata[4:0];
          default:    ;
        endcase
      end
    end
  end

  // FIFO storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TXF_AW-1:0]] <= apb.pwdata;
    if (w_rx_push) r_rx_mem[r_rx_wp[RXF_AW-1:0]] <= rx_wr_data;
  end

  assign apb.pready  = r_pready;
  assign apb.prdata  = w_rdata;
  assign start       = r_start;
  assign trans       = r_trans;
  assign receive     = r_receive;
  assign wr          = r_wr;
  assign clk_div     = r_clk_div;
  assign tx_pkt_size = r_tx_pkt;
  assign rx_pkt_size = r_rx_pkt;
  assign tx_wait     = r_tx_wait;
  assign gpio_oe     = r_gpio_oe;
  assign gpio_out    = r_gpio_out;
  assign tx_rd_data  = r_tx_mem[r_tx_rp[TXF_AW-1:0]];
  assign tx_empty    = w_tx_empty;
  assign rx_full     = w_rx_full;
  assign irq         = |(r_irq_stat & r_irq_mask);
endmodule

`default_nettype wire

// File: tb/tb_cc1200_apb_regs_fifo.sv
//==============================================================================
// Module  : tb_cc1200_apb_regs_fifo
// Directed self-checking bench for cc1200_apb_regs_fifo (default GPIO_W/TXF_AW/RXF_AW).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_cc1200_apb_regs_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, busy, trans, receive, tx_rd_en, tx_empty, rx_wr_en, rx_full, irq;
  logic [3:0]  wr, gpio_oe, gpio_out, gpio_in;
  logic [15:0] clk_div, tx_wait;
  logic [7:0]  tx_pkt_size, rx_pkt_size;
  logic [31:0] tx_rd_data, rx_wr_data, rd;
  logic        se;
  int          errors = 0;
  int          checks = 0;

`ifdef CC1200_APB_SLVERR_EN
  localparam bit c_SLVERR = 1'b1;
`else
  localparam bit c_SLVERR = 1'b0;
`endif

  cc1200_apb_regs_fifo_if bus ();

  cc1200_apb_regs_fifo dut (
    .clk(clk), .rst(rst), .apb(bus), .start(start), .busy(busy), .trans(trans),
    .receive(receive), .wr(wr), .clk_div(clk_div), .tx_pkt_size(tx_pkt_size),
    .rx_pkt_size(rx_pkt_size), .tx_wait(tx_wait), .gpio_oe(gpio_oe), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .tx_rd_en(tx_rd_en), .tx_rd_data(tx_rd_data), .tx_empty(tx_empty),
    .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data), .rx_full(rx_full), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB transfer; optional busy drop lands on the commit edge.
  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic drop_busy, output logic [31:0] r, output logic err);
    bit done = 0;
    r = 32'hX; err = 1'bX;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (bus.pready) begin
        r = bus.prdata; err = bus.pslverr; done = 1;
        if (drop_busy) busy = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    if (!done) check("pready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr32(input logic [7:0] a, input logic [31:0] d);
    apb(1'b1, a, d, 1'b0, rd, se);
  endtask

  task automatic rd32(input logic [7:0] a);
    apb(1'b0, a, 32'd0, 1'b0, rd, se);
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0; tx_rd_en = 1'b0; rx_wr_en = 1'b0; rx_wr_data = '0; gpio_in = 4'hA;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", {31'd0, bus.pready}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_tx_empty", {31'd0, tx_empty}, 32'd1);
    check("rst_rx_full", {31'd0, rx_full}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    rd32(8'h04);  check("status_idle", rd, 32'h0000_000A);
    wr32(8'h14, 32'h0000_1234);
    rd32(8'h14);  check("clkdiv_rd", rd, 32'h0000_1234);
    check("clkdiv_port", {16'd0, clk_div}, 32'h0000_1234);
    rd32(8'h20);  check("gpio_in", rd, 32'h0000_000A);
    wr32(8'h18, 32'h0000_0005);
    check("gpio_oe_port", {28'd0, gpio_oe}, 32'h0000_0005);

    // START pulse and mode bits
    wr32(8'h00, 32'h0000_0007);
    check("start_hi", {31'd0, start}, 32'd1);
    @(posedge clk); #1;
    check("start_lo", {31'd0, start}, 32'd0);
    rd32(8'h00);  check("ctrl_rd", rd, 32'h0000_0006);
    check("trans_recv", {30'd0, trans, receive}, 32'h3);

    // done interrupt
    wr32(8'h34, 32'h0000_0001);
    busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd32(8'h04);  check("status_busy", rd, 32'h0000_000B);
    busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("irq_done", {31'd0, irq}, 32'd1);
    rd32(8'h30);  check("istat_done", rd, 32'h0000_0001);

    // W1C on the same edge as a new done event: set wins
    busy = 1'b1;
    repeat (2) @(posedge clk);
    apb(1'b1, 8'h30, 32'h0000_0001, 1'b1, rd, se);
    rd32(8'h30);  check("istat_setwins", rd, 32'h0000_0001);
    check("irq_setwins", {31'd0, irq}, 32'd1);
    wr32(8'h30, 32'h0000_0001);
    rd32(8'h30);  check("istat_w1c", rd, 32'h0000_0000);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // TX FIFO fill and overflow
    for (int i = 0; i <= 16; i++) wr32(8'h08, i);
    check("tx_ovf_slverr", {31'd0, se}, {31'd0, c_SLVERR});
    rd32(8'h04);  check("status_txfull", rd, 32'h0000_100C);
    rd32(8'h30);  check("istat_txovf", rd, c_SLVERR ? 32'h0 : 32'h8);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx_pop%0d", i), tx_rd_data, i);
      tx_rd_en = 1'b1;
      @(posedge clk); #1;
      tx_rd_en = 1'b0;
    end
    check("tx_empty_after", {31'd0, tx_empty}, 32'd1);
    rd32(8'h30);  check("istat_txempty", rd, c_SLVERR ? 32'h2 : 32'hA);
    wr32(8'h30, 32'h0000_001F);

    // RX FIFO
    @(posedge clk); #1;
    rx_wr_en = 1'b1; rx_wr_data = 32'hA5A5_0001;
    @(posedge clk); #1;
    rx_wr_data = 32'hA5A5_0002;
    @(posedge clk); #1;
    rx_wr_en = 1'b0;
    rd32(8'h04);  check("status_rx2", rd, 32'h0002_0002);
    rd32(8'h30);  check("istat_rxne", rd, 32'h0000_0004);
    rd32(8'h0C);  check("rx_rd1", rd, 32'hA5A5_0001);
    rd32(8'h0C);  check("rx_rd2", rd, 32'hA5A5_0002);
    rd32(8'h0C);  check("rx_rd_empty", rd, 32'h0000_0000);
    check("rx_empty_slverr", {31'd0, se}, {31'd0, c_SLVERR});
    rd32(8'h04);  check("status_rx0", rd, 32'h0000_000A);

    // unmapped address
    wr32(8'h40, 32'hFFFF_FFFF);
    check("unmapped_slverr", {31'd0, se}, {31'd0, c_SLVERR});
    rd32(8'h40);  check("unmapped_rd", rd, 32'h0000_0000);

    // reset in the middle of an access
    wr32(8'h08, 32'h0000_00EE);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'h14; bus.pwdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_pready", {31'd0, bus.pready}, 32'd0);
    check("midrst_clkdiv", {16'd0, clk_div}, 32'd0);
    check("midrst_tx_empty", {31'd0, tx_empty}, 32'd1);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd32(8'h14);  check("midrst_clkdiv_rd", rd, 32'h0000_0000);
    rd32(8'h04);  check("midrst_status", rd, 32'h0000_000A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
